// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed response latency and byte-lane access.
// Optional alignment checking is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | request latched, latency counter running down to 0
    // RESP  | response presented until rsp_ready handshake
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic                  lat_we;
    logic [DEPTH_LOG2+1:0] lat_addr;
    logic [1:0]            lat_size;
    logic [31:0]           lat_wdata;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic                  addr_unused;
    logic                  commit;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            size_eff;
    logic [1:0]            lane;
    logic                  misaligned;
    logic [3:0]            be;
    logic [31:0]           wdata_rep;
    logic [31:0]           rword;
    logic [31:0]           shifted;
    logic [31:0]           load_data;

    assign addr_unused = ^req_addr[31:DEPTH_LOG2+2];
    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign commit      = (state == WAIT) && (cnt == 4'd0);
    assign word_idx    = lat_addr[DEPTH_LOG2+1:2];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign size_eff   = lat_size;
    assign lane       = lat_addr[1:0];
    assign misaligned = (lat_size == 2'b11)
                      || ((lat_size == 2'b01) && lat_addr[0])
                      || ((lat_size == 2'b10) && (lat_addr[1:0] != 2'b00));
`else
    // Without checking, misaligned offsets are snapped down and size 11 acts as a word.
    assign size_eff   = (lat_size == 2'b11) ? 2'b10 : lat_size;
    assign lane       = (size_eff == 2'b00) ? lat_addr[1:0] :
                        (size_eff == 2'b01) ? {lat_addr[1], 1'b0} : 2'b00;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be        = 4'b1111;
        wdata_rep = lat_wdata;
        case (size_eff)
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{lat_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rword   = mem[word_idx];
    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        case (size_eff)
            2'b00:   load_data = {24'd0, shifted[7:0]};
            2'b01:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Storage is deliberately outside the reset domain; a reset in WAIT never reaches commit.
    always_ff @(posedge clk) begin
        if (commit && lat_we && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= 2'b00;
            lat_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (req_valid && req_ready) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr[DEPTH_LOG2+1:0];
                lat_size  <= req_size;
                lat_wdata <= req_wdata;
            end
            if (commit) begin
                rsp_err   <= misaligned;
                rsp_rdata <= (lat_we || misaligned) ? 32'd0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model with per-cycle compare,
// directed vectors with literal expectations, and a LATENCY=3 instance for reset cases.
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int MEMB  = 4 << DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_size;

    logic        b_rst;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [1:0]  b_req_size;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.LATENCY(3), .DEPTH_LOG2(DEPTH)) dut_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_size(b_req_size), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: byte-addressed memory and a transaction age counted in cycles.
    logic [7:0]  m_mem [MEMB];
    bit          m_busy = 0;
    int          m_age  = 0;
    bit          m_we;
    logic [31:0] m_addr, m_wd, m_rdata;
    logic [1:0]  m_size;
    bit          m_err;

    task automatic m_execute();
        int n, a;
        n = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : 4;
        a = int'(m_addr % MEMB);
        m_err   = 0;
        m_rdata = 32'd0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        if (m_size == 2'd3 || (a % n) != 0) begin
            m_err = 1;
            return;
        end
`else
        a = a - (a % n);
`endif
        for (int i = 0; i < n; i++) begin
            if (m_we) m_mem[a+i] = m_wd[8*i +: 8];
            else      m_rdata[8*i +: 8] = m_mem[a+i];
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_age  = 0;
        end else if (m_busy) begin
            if (m_age >= LAT) begin
                if (rsp_ready) m_busy = 0;
            end else begin
                m_age++;
                if (m_age == LAT) m_execute();
            end
        end else if (req_valid) begin
            m_busy = 1;
            m_age  = 0;
            m_we   = req_we;
            m_addr = req_addr;
            m_size = req_size;
            m_wd   = req_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err",   32'(rsp_err), 32'd0);
        end else begin
            chk("m_req_ready", 32'(req_ready), 32'(!m_busy));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= LAT));
            if (m_busy && m_age >= LAT) begin
                chk("m_rsp_rdata", rsp_rdata, m_rdata);
                chk("m_rsp_err",   32'(rsp_err), 32'(m_err));
            end
        end
    end

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic b_wait_rsp(output int n);
        n = 0;
        while (b_rsp_valid !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Called at #1 after a rising edge with the responder idle.
    task automatic txn(input string nm, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
        int n;
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1; req_we = we; req_addr = addr; req_size = size; req_wdata = wd;
        rsp_ready = 1;
        @(posedge clk); #1;
        req_valid = 0;
        wait_rsp(n);
        chk({nm, "_lat"},   32'(n), 32'(LAT));
        chk({nm, "_rdata"}, rsp_rdata, exp_d);
        chk({nm, "_err"},   32'(rsp_err), 32'(exp_e));
        @(posedge clk); #1;
        chk({nm, "_done"},  32'(rsp_valid), 32'd0);
        chk({nm, "_rdy1"},  32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1; b_rst = 1;
        req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_wdata = 0; rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_size = 0; b_req_wdata = 0;
        b_rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        rst = 0; b_rst = 0;
        @(posedge clk); #1;

        txn("st_w10",   1, 32'h10, 2'b10, 32'hDEADBEEF, 32'h0,        0);
        txn("ld_w10",   0, 32'h10, 2'b10, 32'h0,        32'hDEADBEEF, 0);
        txn("st_b12",   1, 32'h12, 2'b00, 32'h0000005A, 32'h0,        0);
        txn("ld_w10b",  0, 32'h10, 2'b10, 32'h0,        32'hDE5ABEEF, 0);
        txn("ld_b13",   0, 32'h13, 2'b00, 32'h0,        32'h000000DE, 0);
        txn("ld_h12",   0, 32'h12, 2'b01, 32'h0,        32'h0000DE5A, 0);
        txn("ld_b10",   0, 32'h10, 2'b00, 32'h0,        32'h000000EF, 0);
        txn("ld_h10",   0, 32'h10, 2'b01, 32'h0,        32'h0000BEEF, 0);

        // Backpressure with a competing request held on the bus.
        req_valid = 1; req_we = 0; req_addr = 32'h10; req_size = 2'b10; rsp_ready = 0;
        @(posedge clk); #1;
        req_valid = 0;
        wait_rsp(n);
        chk("bp_lat", 32'(n), 32'(LAT));
        req_valid = 1; req_addr = 32'h12; req_size = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hDE5ABEEF);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_hs_valid", 32'(rsp_valid), 32'd0);
        chk("bp_hs_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        chk("bp2_busy", 32'(req_ready), 32'd0);
        wait_rsp(n);
        chk("bp2_lat",   32'(n), 32'(LAT));
        chk("bp2_rdata", rsp_rdata, 32'h0000005A);
        @(posedge clk); #1;

        txn("st_wrap",  1, 32'h400, 2'b10, 32'h11223344, 32'h0,        0);
        txn("ld_wrap",  0, 32'h0,   2'b10, 32'h0,        32'h11223344, 0);
        txn("st_w20",   1, 32'h20,  2'b10, 32'h01020304, 32'h0,        0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        txn("st_h21",   1, 32'h21,  2'b01, 32'h0000BBAA, 32'h0,        1);
        txn("ld_w20",   0, 32'h20,  2'b10, 32'h0,        32'h01020304, 0);
        txn("ld_sz3",   0, 32'h10,  2'b11, 32'h0,        32'h0,        1);
        txn("ld_w13",   0, 32'h13,  2'b10, 32'h0,        32'h0,        1);
`else
        txn("st_h21",   1, 32'h21,  2'b01, 32'h0000BBAA, 32'h0,        0);
        txn("ld_w20",   0, 32'h20,  2'b10, 32'h0,        32'h0102BBAA, 0);
        txn("ld_sz3",   0, 32'h10,  2'b11, 32'h0,        32'hDE5ABEEF, 0);
        txn("ld_w13",   0, 32'h13,  2'b10, 32'h0,        32'hDE5ABEEF, 0);
`endif

        // LATENCY=3 instance: reset during WAIT and during RESP.
        b_req_valid = 1; b_req_we = 1; b_req_addr = 32'h40; b_req_size = 2'b10;
        b_req_wdata = 32'hAAAA5555; b_rsp_ready = 1;
        @(posedge clk); #1;
        b_req_valid = 0;
        b_wait_rsp(n);
        chk("b_st_lat", 32'(n), 32'd3);
        @(posedge clk); #1;

        b_req_valid = 1; b_req_wdata = 32'h12345678;
        @(posedge clk); #1;
        b_req_valid = 0;
        chk("b_wait_busy", 32'(b_req_ready), 32'd0);
        @(posedge clk); #1;
        b_rst = 1;
        #1;
        chk("b_rstw_ready", 32'(b_req_ready), 32'd1);
        chk("b_rstw_valid", 32'(b_rsp_valid), 32'd0);
        chk("b_rstw_err",   32'(b_rsp_err), 32'd0);
        @(posedge clk); #1;
        b_rst = 0;

        b_req_valid = 1; b_req_we = 0; b_rsp_ready = 0;
        @(posedge clk); #1;
        b_req_valid = 0;
        b_wait_rsp(n);
        chk("b_ld_lat",   32'(n), 32'd3);
        chk("b_ld_rdata", b_rsp_rdata, 32'hAAAA5555);
        @(posedge clk); #1;
        chk("b_ld_hold",  32'(b_rsp_valid), 32'd1);
        b_rst = 1;
        #1;
        chk("b_rstr_valid", 32'(b_rsp_valid), 32'd0);
        chk("b_rstr_rdata", b_rsp_rdata, 32'd0);
        chk("b_rstr_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_rst = 0;

        b_req_valid = 1; b_req_size = 2'b00; b_req_addr = 32'h41; b_rsp_ready = 1;
        @(posedge clk); #1;
        b_req_valid = 0;
        b_wait_rsp(n);
        chk("b_ld2_lat",   32'(n), 32'd3);
        chk("b_ld2_rdata", b_rsp_rdata, 32'h00000055);
        @(posedge clk); #1;
        chk("b_ld2_done",  32'(b_rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving the number of cycles from request accept to rsp_valid (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 8, giving the number of 32-bit storage words as 2**DEPTH_LOG2.
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock, with all state updated on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned at bit 0.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: load data, right-aligned and zero-extended (the initiator performs sign extension).
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the access was rejected.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0; only one transaction SHALL be outstanding.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
- At acceptance, req_we, req_addr, req_size and req_wdata SHALL be latched.
- The FSM SHALL then move to WAIT with the latency counter loaded to LATENCY-1.
REQ-018 In WAIT, the counter SHALL decrement by 1 per cycle; at count 0, the FSM SHALL go to RESP, so that rsp_valid is first high exactly LATENCY cycles after the accept edge.
REQ-019 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until a rising edge with rsp_ready=1; the FSM SHALL then return to IDLE.
REQ-020 rsp_ready already high on entry to RESP SHALL complete the response in one cycle; req_ready SHALL rise the cycle after the response handshake.
REQ-021 The word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the storage size.
REQ-022 Byte lanes SHALL be little-endian.
- Byte access uses lane addr[1:0].
- Halfword access uses lanes {addr[1],0} and {addr[1],1}.
- Word access uses all four lanes.
REQ-023 A store SHALL update only the selected lanes, and SHALL commit on the edge entering RESP.
- A store response SHALL return rsp_rdata = 0.
REQ-024 A load SHALL sample storage on the edge entering RESP, so that a load accepted after a store response observes the stored data.
REQ-025 req_valid deasserting while in WAIT or RESP SHALL have no effect; requests are ignored when req_ready=0.

Reset
REQ-026 While rst is high, the block SHALL asynchronously set: FSM to IDLE, counter to 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 Reset asserted in WAIT SHALL discard the pending transaction, and a pending store SHALL NOT be committed.
REQ-029 Reset asserted in RESP SHALL drop the response without a handshake.

Configuration
REQ-030 Macro DATA_MEM_ALIGN_CHECK_EN SHALL control alignment checking.
- Defined: a halfword with addr[0]=1, a word with addr[1:0]!=0, or req_size=11 SHALL complete with normal latency, rsp_err=1, rsp_rdata=0, and no storage write.
- Not defined: rsp_err SHALL be constant 0, misaligned low address bits SHALL be forced to alignment (halfword clears bit 0, word clears bits 1:0), and req_size=11 SHALL be treated as word.

Verification
REQ-031 Scenario: LATENCY=2, store word 0xDEADBEEF at 0x10 with rsp_ready=1, then load word at 0x10 -> rsp_valid exactly 2 cycles after each accept; load returns 0xDEADBEEF, rsp_err=0.
REQ-032 Scenario: after REQ-031, store byte 0x5A at 0x12, then load word at 0x10 -> 0xDE5ABEEF; load byte at 0x13 -> 0x000000DE; load halfword at 0x12 -> 0x0000DE5A.
REQ-033 Scenario: hold rsp_ready=0 for 5 cycles in RESP while driving a second req_valid -> rsp_valid and rsp_rdata stable, req_ready=0, second request accepted only after the rsp_ready handshake.
REQ-034 Scenario: DEPTH_LOG2=8, store word 0x11223344 at 0x400, load word at 0x0 -> 0x11223344 (wrap-around).
REQ-035 Scenario: halfword store at 0x21 -> with DATA_MEM_ALIGN_CHECK_EN, rsp_err=1 and the word at 0x20 is unchanged; without the macro, the halfword is written to 0x20 and rsp_err=0.
REQ-036 Scenario: assert rst one cycle after a store is accepted (LATENCY=3) -> outputs at reset values immediately, a subsequent load shows the old data, and the FSM is in IDLE with req_ready=1.
